// File: rtl/apb_initiator_pkg.sv
// rtl/apb_initiator_pkg.sv - shared APB types, initiator FSM state and timeout data
package apb_initiator_pkg;

  typedef logic [31:0] apbAddrSt;
  typedef logic [31:0] apbDataSt;

  typedef enum logic [1:0] {
    APB_INIT_IDLE   = 2'd0,
    APB_INIT_SETUP  = 2'd1,
    APB_INIT_ACCESS = 2'd2,
    APB_INIT_RESP   = 2'd3
  } apbInitStateT;

  // Read data returned when an access is abandoned by the wait limit
  localparam apbDataSt APB_INIT_TIMEOUT_DATA = 32'hBADD_C0DE;

endpackage

// File: rtl/apb_if.sv
// rtl/apb_if.sv - APB bus bundle with initiator (src) and responder (dst) views
interface apb_if;
  import apb_initiator_pkg::*;

  logic     psel;
  logic     penable;
  logic     pwrite;
  apbAddrSt paddr;
  apbDataSt pwdata;
  apbDataSt prdata;
  logic     pready;
  logic     pslverr;

  modport src (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport dst (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );

endinterface

// File: rtl/apb_initiator.sv
// rtl/apb_initiator.sv - single-request APB initiator; optional wait limit under APB_INITIATOR_TIMEOUT_EN
module apb_initiator
  import apb_initiator_pkg::*;
#(
  parameter int APB_ADDR_W     = 32,
  parameter int APB_DATA_W     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [APB_ADDR_W-1:0] req_addr,
  input  logic [APB_DATA_W-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [APB_DATA_W-1:0] rsp_rdata,
  output logic                  rsp_err,
  apb_if.src                    apbReg
);

  apbInitStateT          state;
  logic                  psel_q;
  logic                  penable_q;
  logic                  pwrite_q;
  logic [APB_ADDR_W-1:0] paddr_q;
  logic [APB_DATA_W-1:0] pwdata_q;
  logic                  rsp_valid_q;
  logic [APB_DATA_W-1:0] rsp_rdata_q;
  logic                  rsp_err_q;

  // Held low through reset so no request is taken before the FSM is live
  assign req_ready = (state == APB_INIT_IDLE) && !rst;

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

  assign apbReg.psel    = psel_q;
  assign apbReg.penable = penable_q;
  assign apbReg.pwrite  = pwrite_q;
  assign apbReg.paddr   = apbAddrSt'(paddr_q);
  assign apbReg.pwdata  = apbDataSt'(pwdata_q);

`ifdef APB_INITIATOR_TIMEOUT_EN
  logic [15:0] wait_cnt;
  logic        timeout_hit;

  assign timeout_hit = (wait_cnt == 16'(TIMEOUT_CYCLES));

  // Count ACCESS cycles spent waiting on pready; zeroed in SETUP so ACCESS starts at 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (state == APB_INIT_SETUP) begin
      wait_cnt <= '0;
    end else if (state == APB_INIT_ACCESS && !apbReg.pready) begin
      wait_cnt <= wait_cnt + 16'd1;
    end
  end
`else
  // TIMEOUT_CYCLES has no effect when the wait limit is not built
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

  // Transfer sequencer: IDLE -> SETUP -> ACCESS -> RESP with all bus and response outputs registered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= APB_INIT_IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state)
        APB_INIT_IDLE: begin
          if (req_valid) begin
            pwrite_q <= req_write;
            paddr_q  <= req_addr;
            pwdata_q <= req_wdata;
            psel_q   <= 1'b1;
            state    <= APB_INIT_SETUP;
          end
        end
        APB_INIT_SETUP: begin
          penable_q <= 1'b1;
          state     <= APB_INIT_ACCESS;
        end
        APB_INIT_ACCESS: begin
          if (apbReg.pready) begin
            rsp_rdata_q <= pwrite_q ? '0 : APB_DATA_W'(apbReg.prdata);
            rsp_err_q   <= apbReg.pslverr;
            rsp_valid_q <= 1'b1;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            state       <= APB_INIT_RESP;
          end
`ifdef APB_INITIATOR_TIMEOUT_EN
          else if (timeout_hit) begin
            rsp_rdata_q <= pwrite_q ? '0 : APB_DATA_W'(APB_INIT_TIMEOUT_DATA);
            rsp_err_q   <= 1'b1;
            rsp_valid_q <= 1'b1;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            state       <= APB_INIT_RESP;
          end
`endif
        end
        APB_INIT_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state       <= APB_INIT_IDLE;
          end
        end
        default: state <= APB_INIT_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_initiator.sv
// tb/tb_apb_initiator.sv - directed self-checking bench for apb_initiator
module tb_apb_initiator;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int checks;
  int failures;

  apb_if apb ();

  apb_initiator #(
    .APB_ADDR_W    (32),
    .APB_DATA_W    (32),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .apbReg   (apb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    rst         = 1'b1;
    req_valid   = 1'b0;
    req_write   = 1'b0;
    req_addr    = '0;
    req_wdata   = '0;
    rsp_ready   = 1'b0;
    apb.pready  = 1'b0;
    apb.prdata  = '0;
    apb.pslverr = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_psel", apb.psel, 0);
    chk("rst_penable", apb.penable, 0);
    chk("rst_pwrite", apb.pwrite, 0);
    chk("rst_paddr", apb.paddr, 0);
    chk("rst_pwdata", apb.pwdata, 0);
    #3 rst = 1'b0;
    #1 chk("rel_req_ready", req_ready, 1);
    tick();

    // Read 0x0, zero-wait responder
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0;
    apb.pready = 1'b1; apb.prdata = 32'h0000_005A;
    chk("t1_c0_req_ready", req_ready, 1);
    tick();
    req_valid = 1'b0;
    chk("t1_c1_psel", apb.psel, 1);
    chk("t1_c1_penable", apb.penable, 0);
    chk("t1_c1_paddr", apb.paddr, 32'h0);
    chk("t1_c1_pwrite", apb.pwrite, 0);
    chk("t1_c1_req_ready", req_ready, 0);
    tick();
    chk("t1_c2_psel", apb.psel, 1);
    chk("t1_c2_penable", apb.penable, 1);
    chk("t1_c2_rsp_valid", rsp_valid, 0);
    tick();
    chk("t1_c3_rsp_valid", rsp_valid, 1);
    chk("t1_c3_rsp_rdata", rsp_rdata, 32'h5A);
    chk("t1_c3_rsp_err", rsp_err, 0);
    chk("t1_c3_psel", apb.psel, 0);
    chk("t1_c3_penable", apb.penable, 0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("t1_c4_rsp_valid", rsp_valid, 0);
    chk("t1_c4_req_ready", req_ready, 1);

    // Write 0x4 = 0x12345678, pready low for 3 ACCESS cycles
    apb.pready = 1'b0;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h4; req_wdata = 32'h1234_5678;
    tick();
    req_valid = 1'b0; req_addr = 32'hFFFF_FFFC; req_wdata = 32'hDEAD_BEEF;
    chk("t2_c1_psel", apb.psel, 1);
    chk("t2_c1_pwrite", apb.pwrite, 1);
    for (int c = 2; c <= 5; c++) begin
      tick();
      if (c == 5) apb.pready = 1'b1;
      chk($sformatf("t2_c%0d_paddr", c), apb.paddr, 32'h4);
      chk($sformatf("t2_c%0d_pwdata", c), apb.pwdata, 32'h1234_5678);
      chk($sformatf("t2_c%0d_penable", c), apb.penable, 1);
      chk($sformatf("t2_c%0d_rsp_valid", c), rsp_valid, 0);
    end
    tick();
    apb.pready = 1'b0;
    chk("t2_c6_rsp_valid", rsp_valid, 1);
    chk("t2_c6_rsp_rdata", rsp_rdata, 32'h0);
    chk("t2_c6_rsp_err", rsp_err, 0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // Read 0x8 with pslverr
    apb.pready = 1'b1; apb.prdata = 32'hBADD_C0DE; apb.pslverr = 1'b1;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h8;
    tick();
    req_valid = 1'b0;
    chk("t3_c1_paddr", apb.paddr, 32'h8);
    tick();
    tick();
    chk("t3_c3_rsp_valid", rsp_valid, 1);
    chk("t3_c3_rsp_err", rsp_err, 1);
    chk("t3_c3_rsp_rdata", rsp_rdata, 32'hBADD_C0DE);
    apb.pslverr = 1'b0;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // Response back-pressure with a pending request, then back-to-back
    apb.prdata = 32'h11;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'hC;
    tick();
    tick();
    tick();
    req_addr = 32'h10;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("t4_hold%0d_req_ready", i), req_ready, 0);
      chk($sformatf("t4_hold%0d_rsp_valid", i), rsp_valid, 1);
      chk($sformatf("t4_hold%0d_rsp_rdata", i), rsp_rdata, 32'h11);
      chk($sformatf("t4_hold%0d_rsp_err", i), rsp_err, 0);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    chk("t4_idle_req_ready", req_ready, 1);
    chk("t4_idle_rsp_valid", rsp_valid, 0);
    apb.prdata = 32'h22;
    tick();
    chk("t4_setup_psel", apb.psel, 1);
    chk("t4_setup_penable", apb.penable, 0);
    chk("t4_setup_paddr", apb.paddr, 32'h10);
    tick();
    tick();
    chk("t4_b2b_rsp_rdata", rsp_rdata, 32'h22);
    req_addr = 32'h18;
    tick();
    chk("t4_b2b_req_ready", req_ready, 1);
    tick();
    req_valid = 1'b0;
    chk("t4_b2b_setup_psel", apb.psel, 1);
    chk("t4_b2b_setup_penable", apb.penable, 0);
    chk("t4_b2b_setup_paddr", apb.paddr, 32'h18);
    tick();
    tick();
    tick();
    rsp_ready = 1'b0;
    chk("t4_end_rsp_valid", rsp_valid, 0);

    // Responder that never answers
    apb.pready = 1'b0;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h14;
    tick();
    req_valid = 1'b0;
    tick();
`ifdef APB_INITIATOR_TIMEOUT_EN
    for (int c = 2; c <= 6; c++) begin
      chk($sformatf("t5_c%0d_psel", c), apb.psel, 1);
      tick();
    end
    chk("t5_to_rsp_valid", rsp_valid, 1);
    chk("t5_to_rsp_err", rsp_err, 1);
    chk("t5_to_rsp_rdata", rsp_rdata, 32'hBADD_C0DE);
    chk("t5_to_psel", apb.psel, 0);
    chk("t5_to_penable", apb.penable, 0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_addr = 32'h20;
    tick();
    req_valid = 1'b0;
    tick();
`else
    repeat (100) tick();
    chk("t5_hang_psel", apb.psel, 1);
    chk("t5_hang_penable", apb.penable, 1);
    chk("t5_hang_rsp_valid", rsp_valid, 0);
`endif

    // Reset while in ACCESS
    chk("t6_pre_penable", apb.penable, 1);
    #1 rst = 1'b1;
    #1;
    chk("t6_rst_psel", apb.psel, 0);
    chk("t6_rst_penable", apb.penable, 0);
    chk("t6_rst_req_ready", req_ready, 0);
    tick();
    #4 rst = 1'b0;
    #1;
    chk("t6_rel_req_ready", req_ready, 1);
    chk("t6_rel_rsp_valid", rsp_valid, 0);
    apb.pready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("t6_after%0d_rsp_valid", i), rsp_valid, 0);
      chk($sformatf("t6_after%0d_psel", i), apb.psel, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
